cordic_reg_bridge: RTL and testbench
====================================

CORDIC_REG_BRIDGE -- requirements
Module: cordic_reg_bridge

Interface
REQ-001 SHALL have parameter p_WIDTH, default 32, data/register width; legal values are even and >= 32.
REQ-002 SHALL have parameter p_CHANNELS, default 4, number of CORDIC cores served; legal values are 1..16.
REQ-003 SHALL derive localparam p_ADDR_WIDTH = $clog2(p_CHANNELS) + 3; word address is {channel, offset[2:0]}.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk is the clock and rst is the reset (rst = 0 resets).
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- busValid  in  1  bus request valid
- busWrite  in  1  1 = write, 0 = read
- busAddr  in  p_ADDR_WIDTH  word address
- busWriteData  in  p_WIDTH  write data
- busReady  out  1  request accepted when busValid and busReady are both 1
- busReadValid  out  1  read data valid pulse
- busReadData  out  p_WIDTH  read data
- xInput, yInput, zInput  out  p_CHANNELS*p_WIDTH  per-channel operands; channel i occupies slice i
- controlRegisterInput  out  p_CHANNELS*p_WIDTH  per-channel control/flag register
- xResult, yResult, zResult  in  p_CHANNELS*p_WIDTH  per-channel results
- controlRegisterOutput  in  p_CHANNELS*p_WIDTH  controller-written control/flag value
- controlRegisterWriteEnable  in  p_CHANNELS  controller write strobe, one bit per channel
- coreInterrupt  in  p_CHANNELS  per-core interrupt line
- interrupt  out  1  aggregated interrupt

Function
REQ-006 SHALL map register offsets per channel as follows: 0 = X input (RW), 1 = Y input (RW), 2 = Z input (RW), 3 = control (RW), 4 = X result (RO), 5 = Y result (RO), 6 = Z result (RO), 7 = IRQ register.
REQ-007 SHALL implement a two-state handshake FSM with states IDLE and RESP.
- In IDLE, busReady = 1.
- In RESP, busReady = 0 and busReadValid = 1.
REQ-008 SHALL complete an accepted write in IDLE at the same clock edge; the FSM stays in IDLE, so back-to-back writes sustain one per cycle.
REQ-009 SHALL, on an accepted read, move IDLE->RESP and present registered busReadData for exactly one cycle, then return to IDLE; read latency is 1 cycle.
REQ-010 SHALL hold busReadData at its last value outside RESP.
REQ-011 SHALL ignore writes to read-only offsets; reads of read-only offsets SHALL return the live result inputs sampled at acceptance.
REQ-012 SHALL ignore writes to channel indices >= p_CHANNELS; reads of those indices SHALL return 0.
REQ-013 SHALL treat the control register as follows:
- A bus write updates bits [15:0] only; bits [p_WIDTH-1:16] (flags) are read-only from the bus.
- Controller write-enable loads the full word from controlRegisterOutput.
REQ-014 SHALL, on the same cycle as a bus write and a controller write to one channel's control register, take bits [15:0] from the bus and bits [p_WIDTH-1:16] from the controller.
REQ-015 SHALL self-clear control bit 0 (Start) one cycle after it is set by the bus, giving a 1-cycle pulse, unless the controller writes a 1 to it in that same cycle.
REQ-016 SHALL implement the IRQ register (offset 7) as follows:
- Bit 0 is pending: set on a rising edge of coreInterrupt[i] and cleared by writing 1 to it (W1C).
- Bit 1 is enable (RW).
- Other bits read 0.
REQ-017 SHALL let set win when a pending set and a W1C clear coincide.
REQ-018 SHALL register the interrupt output as OR over channels of (pending & enable), so it goes high 1 cycle after pending/enable are updated.

Reset
REQ-019 SHALL, while rst = 0, drive every register and output to 0 and place the FSM in IDLE; this includes all operand and control registers, pending, enable, the coreInterrupt edge-history flops, busReadData, busReadValid and interrupt.
REQ-020 SHALL, when rst asserts in RESP, abort the read; no busReadValid pulse is produced after rst releases.
REQ-021 SHALL raise busReady on the first clock edge after rst releases.

Verification
REQ-022 SHALL pass: write 0x1234_5678 to channel 2 offset 0, then read channel 2 offset 0 -> busReadValid one cycle after acceptance with data 0x1234_5678, and xInput slice 2 = 0x1234_5678.
REQ-023 SHALL pass: bus writes 0xFFFF_FFFF to control ch0 -> controlRegisterInput[0] = 0x0000_FFFF for one cycle, then 0x0000_FFFE once Start self-clears.
REQ-024 SHALL pass: bus writes 0x0000_0004 to control ch1 in the same cycle the controller writes 0xABCD_0000 on ch1 -> register = 0xABCD_0004.
REQ-025 SHALL pass: enable = 1 on ch3, coreInterrupt[3] rises -> pending = 1 and interrupt = 1 one cycle later; W1C in the same cycle as a new rising edge -> pending stays 1.
REQ-026 SHALL pass: with p_CHANNELS = 3, read channel 3 offset 0 -> data 0; write channel 3 -> no output slice changes.
REQ-027 SHALL pass: rst low during RESP -> busReadValid = 0 immediately, with all outputs 0 until release.

Source files
------------

// File: rtl/cordic_reg_bridge.sv
// Register bridge between a simple valid/ready bus and a bank of CORDIC cores.
// Per channel: operands, control/flag register, result readback and a per-core IRQ register.
module cordic_reg_bridge #(
    parameter int p_WIDTH = 32,
    parameter int p_CHANNELS = 4,
    localparam int p_ADDR_WIDTH = $clog2(p_CHANNELS) + 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            busValid,
    input  logic                            busWrite,
    input  logic [p_ADDR_WIDTH-1:0]         busAddr,
    input  logic [p_WIDTH-1:0]              busWriteData,
    output logic                            busReady,
    output logic                            busReadValid,
    output logic [p_WIDTH-1:0]              busReadData,
    output logic [p_CHANNELS*p_WIDTH-1:0]   xInput,
    output logic [p_CHANNELS*p_WIDTH-1:0]   yInput,
    output logic [p_CHANNELS*p_WIDTH-1:0]   zInput,
    output logic [p_CHANNELS*p_WIDTH-1:0]   controlRegisterInput,
    input  logic [p_CHANNELS*p_WIDTH-1:0]   xResult,
    input  logic [p_CHANNELS*p_WIDTH-1:0]   yResult,
    input  logic [p_CHANNELS*p_WIDTH-1:0]   zResult,
    input  logic [p_CHANNELS*p_WIDTH-1:0]   controlRegisterOutput,
    input  logic [p_CHANNELS-1:0]           controlRegisterWriteEnable,
    input  logic [p_CHANNELS-1:0]           coreInterrupt,
    output logic                            interrupt
);
    // Channel field gets one spare MSB so it is never zero-width and out-of-range indices stay visible.
    localparam int p_CW = p_ADDR_WIDTH - 2;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

    state_t                          state_q, state_d;
    logic                            ready_q, ready_d;
    logic                            rvalid_q, rvalid_d;
    logic [p_WIDTH-1:0]              rdata_q, rdata_d;
    logic [p_CHANNELS*p_WIDTH-1:0]   x_q, x_d, y_q, y_d, z_q, z_d, ctrl_q, ctrl_d;
    logic [p_CHANNELS-1:0]           start_clr_q, start_clr_d;
    logic [p_CHANNELS-1:0]           pend_q, pend_d, en_q, en_d;
    logic [p_CHANNELS-1:0]           irq_prev_q, irq_prev_d;
    logic                            irq_q, irq_d;

    logic                            accept_s, wr_s, rd_s;
    logic [p_ADDR_WIDTH:0]           addr_ext_s;
    logic [p_CW-1:0]                 chan_s;
    logic [2:0]                      off_s;
    logic [p_CHANNELS-1:0]           wr_hit_s;
    logic [p_WIDTH-1:0]              rd_mux_s;

    function automatic logic [p_WIDTH-1:0] sel_word(
        input logic [2:0]         off,
        input logic [p_WIDTH-1:0] x, y, z, c, xr, yr, zr,
        input logic               en,
        input logic               pend
    );
        case (off)
            3'd0:    sel_word = x;
            3'd1:    sel_word = y;
            3'd2:    sel_word = z;
            3'd3:    sel_word = c;
            3'd4:    sel_word = xr;
            3'd5:    sel_word = yr;
            3'd6:    sel_word = zr;
            3'd7:    sel_word = {{(p_WIDTH-2){1'b0}}, en, pend};
            default: sel_word = '0;
        endcase
    endfunction

    assign accept_s   = busValid & ready_q;
    assign wr_s       = accept_s & busWrite;
    assign rd_s       = accept_s & ~busWrite;
    assign addr_ext_s = {1'b0, busAddr};
    assign chan_s     = addr_ext_s[p_ADDR_WIDTH:3];
    assign off_s      = busAddr[2:0];

    // Handshake FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = rd_s ? ST_RESP : ST_IDLE;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake FSM outputs, registered so they are all low during reset.
    always_comb begin
        ready_d  = (state_d == ST_IDLE);
        rvalid_d = (state_d == ST_RESP);
    end

    // Read-data mux; unmatched channel indices fall through as zero.
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < p_CHANNELS; i++) begin
            rd_mux_s = (chan_s == p_CW'(i)) ?
                sel_word(off_s, x_q[i*p_WIDTH +: p_WIDTH], y_q[i*p_WIDTH +: p_WIDTH],
                         z_q[i*p_WIDTH +: p_WIDTH], ctrl_q[i*p_WIDTH +: p_WIDTH],
                         xResult[i*p_WIDTH +: p_WIDTH], yResult[i*p_WIDTH +: p_WIDTH],
                         zResult[i*p_WIDTH +: p_WIDTH], en_q[i], pend_q[i]) : rd_mux_s;
        end
        rdata_d = rd_s ? rd_mux_s : rdata_q;
    end

    // Per-channel register updates: operands, control merge with Start self-clear, IRQ.
    always_comb begin
        wr_hit_s    = '0;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ctrl_d      = ctrl_q;
        start_clr_d = '0;
        pend_d      = pend_q;
        en_d        = en_q;
        irq_prev_d  = coreInterrupt;
        for (int i = 0; i < p_CHANNELS; i++) begin
            wr_hit_s[i] = wr_s && (chan_s == p_CW'(i));
            x_d[i*p_WIDTH +: p_WIDTH] = (wr_hit_s[i] && off_s == 3'd0) ? busWriteData : x_q[i*p_WIDTH +: p_WIDTH];
            y_d[i*p_WIDTH +: p_WIDTH] = (wr_hit_s[i] && off_s == 3'd1) ? busWriteData : y_q[i*p_WIDTH +: p_WIDTH];
            z_d[i*p_WIDTH +: p_WIDTH] = (wr_hit_s[i] && off_s == 3'd2) ? busWriteData : z_q[i*p_WIDTH +: p_WIDTH];
            // Controller load wins over self-clear; bus low half wins over both.
            ctrl_d[i*p_WIDTH +: p_WIDTH] = controlRegisterWriteEnable[i] ?
                controlRegisterOutput[i*p_WIDTH +: p_WIDTH] :
                {ctrl_q[i*p_WIDTH+1 +: p_WIDTH-1], ctrl_q[i*p_WIDTH] & ~start_clr_q[i]};
            ctrl_d[i*p_WIDTH +: 16] = (wr_hit_s[i] && off_s == 3'd3) ? busWriteData[15:0] : ctrl_d[i*p_WIDTH +: 16];
            start_clr_d[i] = wr_hit_s[i] && (off_s == 3'd3) && busWriteData[0];
            pend_d[i] = (coreInterrupt[i] & ~irq_prev_q[i]) |
                        (pend_q[i] & ~(wr_hit_s[i] && (off_s == 3'd7) && busWriteData[0]));
            en_d[i] = (wr_hit_s[i] && off_s == 3'd7) ? busWriteData[1] : en_q[i];
        end
        irq_d = |(pend_q & en_q);
    end

    // State and register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ctrl_q      <= '0;
            start_clr_q <= '0;
            pend_q      <= '0;
            en_q        <= '0;
            irq_prev_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ctrl_q      <= ctrl_d;
            start_clr_q <= start_clr_d;
            pend_q      <= pend_d;
            en_q        <= en_d;
            irq_prev_q  <= irq_prev_d;
            irq_q       <= irq_d;
        end
    end

    assign busReady             = ready_q;
    assign busReadValid         = rvalid_q;
    assign busReadData          = rdata_q;
    assign xInput               = x_q;
    assign yInput               = y_q;
    assign zInput               = z_q;
    assign controlRegisterInput = ctrl_q;
    assign interrupt            = irq_q;

endmodule

// File: tb/tb_cordic_reg_bridge.sv
// Directed bench for cordic_reg_bridge: a 4-channel instance plus a 3-channel instance
// for the out-of-range channel behaviour.
module tb_cordic_reg_bridge;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bv = 1'b0, bv3 = 1'b0;
    logic          busWrite = 1'b0;
    logic [4:0]    busAddr = 5'd0;
    logic [W-1:0]  busWriteData = 32'd0;

    logic          rdy, rv, irq;
    logic [W-1:0]  rdata;
    logic [4*W-1:0] xi, yi, zi, ci;
    logic [4*W-1:0] xr = '0, yr = '0, zr = '0, cro = '0;
    logic [3:0]    cwe = 4'd0, cirq = 4'd0;

    logic          rdy3, rv3, irq3;
    logic [W-1:0]  rdata3;
    logic [3*W-1:0] xi3, yi3, zi3, ci3;
    logic [3*W-1:0] zero3 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_reg_bridge #(.p_WIDTH(32), .p_CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .busValid(bv), .busWrite(busWrite), .busAddr(busAddr),
        .busWriteData(busWriteData), .busReady(rdy), .busReadValid(rv), .busReadData(rdata),
        .xInput(xi), .yInput(yi), .zInput(zi), .controlRegisterInput(ci),
        .xResult(xr), .yResult(yr), .zResult(zr), .controlRegisterOutput(cro),
        .controlRegisterWriteEnable(cwe), .coreInterrupt(cirq), .interrupt(irq)
    );

    cordic_reg_bridge #(.p_WIDTH(32), .p_CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .busValid(bv3), .busWrite(busWrite), .busAddr(busAddr),
        .busWriteData(busWriteData), .busReady(rdy3), .busReadValid(rv3), .busReadData(rdata3),
        .xInput(xi3), .yInput(yi3), .zInput(zi3), .controlRegisterInput(ci3),
        .xResult(zero3), .yResult(zero3), .zResult(zero3), .controlRegisterOutput(zero3),
        .controlRegisterWriteEnable(3'd0), .coreInterrupt(3'd0), .interrupt(irq3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted bus request; returns 1 time unit after the accepting edge.
    task automatic bus_op(input logic sel3, input logic wr, input logic [4:0] addr, input logic [W-1:0] data);
        busWrite = wr;
        busAddr = addr;
        busWriteData = data;
        if (sel3) bv3 = 1'b1;
        else bv = 1'b1;
        tick();
        bv = 1'b0;
        bv3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({rdy, rv, irq, rdata} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b rv=%b irq=%b data=%h want 0", rdy, rv, irq, rdata);
        end
        checks++;
        if ({xi, yi, zi, ci} !== '0) begin
            errors++;
            $display("FAIL reset_regs got x=%h c=%h want 0", xi, ci);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", rdy);
        end
        tick();
        checks++;
        if (rdy !== 1'b1 || rdy3 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b/%b want 1", rdy, rdy3);
        end
    endtask

    task automatic test_write_read();
        bus_op(1'b0, 1'b1, 5'b10_000, 32'h1234_5678);
        checks++;
        if (xi[2*W +: W] !== 32'h1234_5678 || xi[0 +: 2*W] !== '0) begin
            errors++;
            $display("FAIL write_x_ch2 got %h want 12345678 in slice 2 only", xi);
        end
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL rv_idle got %b want 0", rv);
        end
        bus_op(1'b0, 1'b0, 5'b10_000, 32'h0);
        checks++;
        if (rv !== 1'b1 || rdy !== 1'b0 || rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_x_ch2 got rv=%b rdy=%b data=%h want 1 0 12345678", rv, rdy, rdata);
        end
        tick();
        checks++;
        if (rv !== 1'b0 || rdy !== 1'b1 || rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_end got rv=%b rdy=%b data=%h want 0 1 12345678 held", rv, rdy, rdata);
        end
    endtask

    task automatic test_back_to_back();
        busWrite = 1'b1;
        bv = 1'b1;
        busAddr = 5'b00_000; busWriteData = 32'hAAAA_0001; tick();
        busAddr = 5'b00_001; busWriteData = 32'hBBBB_0002; tick();
        busAddr = 5'b00_010; busWriteData = 32'hCCCC_0003; tick();
        bv = 1'b0;
        checks++;
        if (xi[0 +: W] !== 32'hAAAA_0001 || yi[0 +: W] !== 32'hBBBB_0002 || zi[0 +: W] !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL back_to_back got x=%h y=%h z=%h want aaaa0001 bbbb0002 cccc0003",
                     xi[0 +: W], yi[0 +: W], zi[0 +: W]);
        end
    endtask

    task automatic test_result_read();
        zr[0 +: W] = 32'h0BAD_F00D;
        yr[1*W +: W] = 32'hCAFE_BABE;
        bus_op(1'b0, 1'b1, 5'b01_101, 32'h1111_1111);
        bus_op(1'b0, 1'b0, 5'b01_101, 32'h0);
        checks++;
        if (rdata !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL read_y_result_ch1 got %h want cafebabe", rdata);
        end
        tick();
        bus_op(1'b0, 1'b0, 5'b00_110, 32'h0);
        checks++;
        if (rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL read_z_result_ch0 got %h want 0badf00d", rdata);
        end
        tick();
    endtask

    task automatic test_control_start();
        bus_op(1'b0, 1'b1, 5'b00_011, 32'hFFFF_FFFF);
        checks++;
        if (ci[0 +: W] !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL ctrl_start_set got %h want 0000ffff", ci[0 +: W]);
        end
        tick();
        checks++;
        if (ci[0 +: W] !== 32'h0000_FFFE) begin
            errors++;
            $display("FAIL ctrl_start_clear got %h want 0000fffe", ci[0 +: W]);
        end
        bus_op(1'b0, 1'b1, 5'b00_011, 32'h0000_0001);
        cwe = 4'b0001;
        cro[0 +: W] = 32'h0000_0001;
        tick();
        cwe = 4'b0000;
        checks++;
        if (ci[0 +: W] !== 32'h0000_0001) begin
            errors++;
            $display("FAIL ctrl_start_kept got %h want 00000001", ci[0 +: W]);
        end
        tick();
        checks++;
        if (ci[0 +: W] !== 32'h0000_0001) begin
            errors++;
            $display("FAIL ctrl_start_stable got %h want 00000001", ci[0 +: W]);
        end
    endtask

    task automatic test_control_merge();
        cwe = 4'b0010;
        cro[1*W +: W] = 32'hABCD_0000;
        bus_op(1'b0, 1'b1, 5'b01_011, 32'h0000_0004);
        cwe = 4'b0000;
        checks++;
        if (ci[1*W +: W] !== 32'hABCD_0004) begin
            errors++;
            $display("FAIL ctrl_merge got %h want abcd0004", ci[1*W +: W]);
        end
        bus_op(1'b0, 1'b1, 5'b01_011, 32'h5555_0010);
        checks++;
        if (ci[1*W +: W] !== 32'hABCD_0010) begin
            errors++;
            $display("FAIL ctrl_flags_ro got %h want abcd0010", ci[1*W +: W]);
        end
    endtask

    task automatic test_irq();
        bus_op(1'b0, 1'b1, 5'b11_111, 32'h0000_0002);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_enable_only got %b want 0", irq);
        end
        cirq[3] = 1'b1;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency got %b want 0 on pending edge", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_raise got %b want 1", irq);
        end
        bus_op(1'b0, 1'b0, 5'b11_111, 32'h0);
        checks++;
        if (rdata !== 32'h0000_0003) begin
            errors++;
            $display("FAIL irq_reg_read got %h want 00000003", rdata);
        end
        tick();
        cirq[3] = 1'b0;
        tick();
        cirq[3] = 1'b1;
        bus_op(1'b0, 1'b1, 5'b11_111, 32'h0000_0003);
        bus_op(1'b0, 1'b0, 5'b11_111, 32'h0);
        checks++;
        if (rdata !== 32'h0000_0003 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got data=%h irq=%b want 00000003 1", rdata, irq);
        end
        tick();
        bus_op(1'b0, 1'b1, 5'b11_111, 32'h0000_0003);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_w1c_latency got %b want 1", irq);
        end
        bus_op(1'b0, 1'b0, 5'b11_111, 32'h0);
        checks++;
        if (rdata !== 32'h0000_0002 || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c got data=%h irq=%b want 00000002 0", rdata, irq);
        end
        tick();
        cirq[3] = 1'b0;
    endtask

    task automatic test_invalid_channel();
        bus_op(1'b1, 1'b1, 5'b10_000, 32'h1111_1111);
        bus_op(1'b1, 1'b1, 5'b11_000, 32'hDEAD_BEEF);
        bus_op(1'b1, 1'b1, 5'b11_011, 32'h0000_FFFF);
        checks++;
        if (xi3 !== {32'h1111_1111, 64'h0} || ci3 !== '0 || yi3 !== '0 || zi3 !== '0) begin
            errors++;
            $display("FAIL oob_write got x=%h c=%h want only slice 2 = 11111111", xi3, ci3);
        end
        bus_op(1'b1, 1'b0, 5'b10_000, 32'h0);
        checks++;
        if (rv3 !== 1'b1 || rdata3 !== 32'h1111_1111) begin
            errors++;
            $display("FAIL ch3_read_valid_ch got rv=%b data=%h want 1 11111111", rv3, rdata3);
        end
        tick();
        bus_op(1'b1, 1'b0, 5'b11_000, 32'h0);
        checks++;
        if (rv3 !== 1'b1 || rdata3 !== 32'h0) begin
            errors++;
            $display("FAIL oob_read got rv=%b data=%h want 1 00000000", rv3, rdata3);
        end
        tick();
    endtask

    task automatic test_reset_in_resp();
        bus_op(1'b0, 1'b0, 5'b10_000, 32'h0);
        checks++;
        if (rv !== 1'b1) begin
            errors++;
            $display("FAIL resp_entered got %b want 1", rv);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rv, rdy, irq, rdata} !== {3'b000, 32'h0} || {xi, yi, zi, ci} !== '0 || xi3 !== '0) begin
            errors++;
            $display("FAIL reset_in_resp got rv=%b rdy=%b data=%h x=%h want 0", rv, rdy, rdata, xi);
        end
        tick();
        checks++;
        if (rv !== 1'b0 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got rv=%b rdy=%b want 0 0", rv, rdy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (rv !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL after_abort got rv=%b rdy=%b want 0 1", rv, rdy);
        end
        tick();
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL no_late_pulse got %b want 0", rv);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_result_read();
        test_control_start();
        test_control_merge();
        test_irq();
        test_invalid_channel();
        test_reset_in_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
